// File: rtl/prewish_button_mentor.sv
// ---------------------------------------------------------------------------
// prewish_button_mentor
//
// User-driven pattern source for prewish_blinky. It synchronises and
// debounces an active-low pushbutton. Each accepted press steps through a
// fixed four-entry table of blink masks and issues a one-cycle strobe that
// carries the new mask. Right after reset it sends pattern 0 once, so blinky
// always starts from a known mask.
//
// Parameters
//   DEBOUNCE_BITS  debounce counter width. The button level must stay
//                  stable for 2**DEBOUNCE_BITS clocks before it is accepted.
//
// Ports
//   CLK_I      in   1  system clock
//   RST_I      in   1  asynchronous reset, active low
//   iN_button  in   1  raw pushbutton, active low, asynchronous to CLK_I
//   STB_O      out  1  one-cycle strobe: DAT_O/IDX_O are valid
//   DAT_O      out  8  blink mask, held between strobes
//   IDX_O      out  2  index of the mask on DAT_O, held between strobes
// ---------------------------------------------------------------------------
module prewish_button_mentor #(
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       iN_button,
    output logic       STB_O,
    output logic [7:0] DAT_O,
    output logic [1:0] IDX_O
);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        SEND = 2'd2,
        HELD = 2'd3
    } state_t;

    localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX = '1;

    // Fixed blink-mask table indexed by the pattern index
    function automatic logic [7:0] pattern(input logic [1:0] idx);
        logic [7:0] mask;
        case (idx)
            2'd0:    mask = 8'b1010_0000;
            2'd1:    mask = 8'b1111_0000;
            2'd2:    mask = 8'b1010_1010;
            default: mask = 8'b1100_1100;
        endcase
        return mask;
    endfunction

    logic                     sync_1;
    logic                     btn_s;
    logic                     debounced;
    logic [DEBOUNCE_BITS-1:0] cnt;
    logic                     press_evt;

    state_t                   state;
    state_t                   next_state;
    logic [1:0]               idx_q;
    logic [1:0]               next_idx;
    logic                     stb_d;
    logic [7:0]               dat_d;
    logic [1:0]               idx_out_d;

    // Two-flop synchroniser. Both flops reset to the released level so that
    // leaving reset never looks like a press.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            sync_1 <= 1'b1;
            btn_s  <= 1'b1;
        end else begin
            sync_1 <= iN_button;
            btn_s  <= sync_1;
        end
    end

    // Debouncer. The counter runs only while the synchronised level disagrees
    // with the accepted level. Any return to agreement wipes the count, so a
    // glitch shorter than the full window leaves no trace. Taking the new
    // level at terminal count also clears the counter, so it cannot wrap.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            debounced <= 1'b1;
            cnt       <= '0;
        end else if (btn_s == debounced) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            debounced <= btn_s;
            cnt       <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // High in the cycle whose closing edge takes a new low (pressed) level.
    // Only the 1->0 direction counts as a press.
    assign press_evt = debounced && !btn_s && (cnt == CNT_MAX);

    // State, working index and registered outputs. The outputs are registered
    // so that they read as cleared the moment reset asserts, and so that the
    // INIT strobe appears only after the first edge out of reset.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state <= INIT;
            idx_q <= 2'd0;
            STB_O <= 1'b0;
            DAT_O <= 8'h00;
            IDX_O <= 2'd0;
        end else begin
            state <= next_state;
            idx_q <= next_idx;
            STB_O <= stb_d;
            DAT_O <= dat_d;
            IDX_O <= idx_out_d;
        end
    end

    // Next-state and next-output logic. DAT_O and IDX_O hold their values
    // unless a strobe is issued. The working index moves on at the press;
    // the outputs follow one edge later, together with the strobe. HELD waits
    // for the debounced release, which gives exactly one strobe per press no
    // matter how long the button is held or how much it bounces.
    always_comb begin
        next_state = state;
        next_idx   = idx_q;
        stb_d      = 1'b0;
        dat_d      = DAT_O;
        idx_out_d  = IDX_O;
        case (state)
            INIT: begin
                stb_d      = 1'b1;
                dat_d      = pattern(2'd0);
                idx_out_d  = 2'd0;
                next_idx   = 2'd0;
                next_state = IDLE;
            end
            IDLE: begin
                if (press_evt) begin
                    next_idx   = idx_q + 2'd1;
                    next_state = SEND;
                end
            end
            SEND: begin
                stb_d      = 1'b1;
                dat_d      = pattern(idx_q);
                idx_out_d  = idx_q;
                next_state = HELD;
            end
            HELD: begin
                if (debounced) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_prewish_button_mentor.sv
// ---------------------------------------------------------------------------
// tb_prewish_button_mentor
//
// Directed bench for prewish_button_mentor with DEBOUNCE_BITS = 3, so the
// debounce window is 8 clocks. Inputs change and outputs are sampled on the
// falling clock edge. Every expected value is written out by hand.
// ---------------------------------------------------------------------------
module tb_prewish_button_mentor;

    logic       CLK_I;
    logic       RST_I;
    logic       iN_button;
    logic       STB_O;
    logic [7:0] DAT_O;
    logic [1:0] IDX_O;

    int vectors;
    int miscompares;
    int stb_count;
    int base_count;
    logic prev_stb;

    logic [7:0] exp_dat [4];
    logic [1:0] exp_idx [4];

    prewish_button_mentor #(
        .DEBOUNCE_BITS(3)
    ) dut (
        .CLK_I    (CLK_I),
        .RST_I    (RST_I),
        .iN_button(iN_button),
        .STB_O    (STB_O),
        .DAT_O    (DAT_O),
        .IDX_O    (IDX_O)
    );

    // 10 ns clock
    initial begin
        CLK_I = 1'b0;
        forever #5 CLK_I = ~CLK_I;
    end

    // Count strobes and flag any strobe that lasts two cycles in a row
    always @(negedge CLK_I) begin
        if (STB_O === 1'b1) begin
            stb_count++;
            vectors++;
            assert (prev_stb !== 1'b1) else begin
                miscompares++;
                $error("[TB] FAIL stb_back_to_back: observed %b %b expected not both 1",
                       prev_stb, STB_O);
            end
        end
        prev_stb = STB_O;
    end

    // Drive the button level, then wait the given number of falling edges
    task automatic applyStimulus(input logic level, input int cycles);
        iN_button = level;
        repeat (cycles) @(negedge CLK_I);
    endtask

    // One comparison: count it, and report a failure with both values
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        stb_count   = 0;
        prev_stb    = 1'b0;
        exp_dat[0] = 8'hAA; exp_idx[0] = 2'd2;
        exp_dat[1] = 8'hCC; exp_idx[1] = 2'd3;
        exp_dat[2] = 8'hA0; exp_idx[2] = 2'd0;
        exp_dat[3] = 8'hF0; exp_idx[3] = 2'd1;

        RST_I     = 1'b0;
        iN_button = 1'b1;
        repeat (3) @(negedge CLK_I);

        // Reset values
        $display("[TB] reset values");
        checkOutput("rst_stb", 32'(STB_O), 32'd0);
        checkOutput("rst_dat", 32'(DAT_O), 32'h00);
        checkOutput("rst_idx", 32'(IDX_O), 32'd0);

        // INIT strobe on the first edge after reset is released
        $display("[TB] init strobe");
        RST_I = 1'b1;
        applyStimulus(1'b1, 1);
        checkOutput("init_stb", 32'(STB_O), 32'd1);
        checkOutput("init_dat", 32'(DAT_O), 32'hA0);
        checkOutput("init_idx", 32'(IDX_O), 32'd0);
        applyStimulus(1'b1, 1);
        checkOutput("init_stb_low", 32'(STB_O), 32'd0);
        checkOutput("init_dat_hold", 32'(DAT_O), 32'hA0);
        applyStimulus(1'b1, 5);

        // Clean press held 20 cycles: 2 sync + 8 debounce + 1 state edge
        $display("[TB] clean press");
        base_count = stb_count;
        applyStimulus(1'b0, 10);
        checkOutput("press_not_early", 32'(STB_O), 32'd0);
        applyStimulus(1'b0, 1);
        checkOutput("press_stb", 32'(STB_O), 32'd1);
        checkOutput("press_dat", 32'(DAT_O), 32'hF0);
        checkOutput("press_idx", 32'(IDX_O), 32'd1);
        applyStimulus(1'b0, 9);
        applyStimulus(1'b1, 15);
        checkOutput("press_one_stb", 32'(stb_count), 32'(base_count + 1));
        checkOutput("release_dat_hold", 32'(DAT_O), 32'hF0);

        // Glitches of 1, 3 and 7 cycles are all shorter than the window
        $display("[TB] glitches");
        base_count = stb_count;
        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 12);
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 12);
        applyStimulus(1'b0, 7);
        applyStimulus(1'b1, 12);
        checkOutput("glitch_no_stb", 32'(stb_count), 32'(base_count));
        checkOutput("glitch_idx", 32'(IDX_O), 32'd1);
        checkOutput("glitch_dat", 32'(DAT_O), 32'hF0);

        // Four clean presses starting at index 1: AA, CC, A0 (wrap), F0
        $display("[TB] four presses");
        for (int i = 0; i < 4; i++) begin
            base_count = stb_count;
            applyStimulus(1'b0, 12);
            checkOutput("seq_stb", 32'(stb_count), 32'(base_count + 1));
            checkOutput("seq_dat", 32'(DAT_O), 32'(exp_dat[i]));
            checkOutput("seq_idx", 32'(IDX_O), 32'(exp_idx[i]));
            applyStimulus(1'b1, 12);
        end

        // Bouncy press, then a bouncy release
        $display("[TB] bounce");
        base_count = stb_count;
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 2);
        applyStimulus(1'b0, 15);
        checkOutput("bounce_press_stb", 32'(stb_count), 32'(base_count + 1));
        checkOutput("bounce_press_dat", 32'(DAT_O), 32'hAA);
        checkOutput("bounce_press_idx", 32'(IDX_O), 32'd2);
        base_count = stb_count;
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b1, 15);
        checkOutput("bounce_release_stb", 32'(stb_count), 32'(base_count));
        checkOutput("bounce_release_idx", 32'(IDX_O), 32'd2);

        // Reset during a press count clears outputs at once; INIT follows
        $display("[TB] reset mid-debounce");
        applyStimulus(1'b0, 5);
        #2 RST_I = 1'b0;
        #1;
        checkOutput("async_rst_stb", 32'(STB_O), 32'd0);
        checkOutput("async_rst_dat", 32'(DAT_O), 32'h00);
        checkOutput("async_rst_idx", 32'(IDX_O), 32'd0);
        iN_button = 1'b1;
        repeat (3) @(negedge CLK_I);
        RST_I = 1'b1;
        base_count = stb_count;
        applyStimulus(1'b1, 1);
        checkOutput("reinit_stb", 32'(STB_O), 32'd1);
        checkOutput("reinit_dat", 32'(DAT_O), 32'hA0);
        checkOutput("reinit_idx", 32'(IDX_O), 32'd0);
        applyStimulus(1'b1, 20);
        checkOutput("reinit_only_stb", 32'(stb_count), 32'(base_count + 1));
        checkOutput("reinit_dat_hold", 32'(DAT_O), 32'hA0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
